// File: rtl/dmem_arb_pkg.sv
// Shared state encoding, default parameters and port identifiers for the
// data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_BURST    = 8;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic [1:0] PORT_NONE = 2'd0;
    localparam logic [1:0] PORT_CPU  = 2'd1;
    localparam logic [1:0] PORT_DMA  = 2'd2;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive cycles a requester was held off; flags the
// requester as starved once the count reaches LIMIT.
module arb_wait_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic starved
);
    localparam int              W       = $clog2(LIMIT + 1);
    localparam logic [W-1:0]    LIMIT_V = W'(LIMIT);
    localparam logic [W-1:0]    ONE_V   = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT_V) begin
            cnt_d = cnt_q + ONE_V;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a DMA burst
// master. Optional statistics counters are enabled by DMEM_ARBITER_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_last,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARBITER_STATS_EN
    ,
    output logic [15:0] stat_cpu_stall_cycles,
    output logic [15:0] stat_dma_beats
`endif
);
    localparam int           BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

    arb_state_e     state_q, state_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [1:0]     gnt_id;
    logic           cpu_starved, dma_starved;

    arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_cpu_wait (
        .clk     (clk),
        .reset   (reset),
        .req     (cpu_req),
        .gnt     (cpu_gnt),
        .starved (cpu_starved)
    );

    arb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_dma_wait (
        .clk     (clk),
        .reset   (reset),
        .req     (dma_req),
        .gnt     (dma_gnt),
        .starved (dma_starved)
    );

    // Reset masks the grant so every output collapses without waiting for a clock.
    always_comb begin
        gnt_id = PORT_NONE;
        if (!reset) begin
            gnt_id = PORT_NONE;
        end else if (cpu_req && cpu_starved) begin
            gnt_id = PORT_CPU;
        end else if (state_q == DMA_BURST && dma_req) begin
            gnt_id = PORT_DMA;
        end else if (state_q == IDLE && dma_req && dma_starved) begin
            gnt_id = PORT_DMA;
        end else if (cpu_req) begin
            gnt_id = PORT_CPU;
        end else if (dma_req) begin
            gnt_id = PORT_DMA;
        end
    end

    assign cpu_gnt   = (gnt_id == PORT_CPU);
    assign dma_gnt   = (gnt_id == PORT_DMA);
    assign cpu_stall = reset && cpu_req && !cpu_gnt;

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        dma_rdata = '0;
        case (gnt_id)
            PORT_CPU: begin
                mem_read  = !cpu_we;
                mem_write = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_rdata = mem_rdata;
            end
            PORT_DMA: begin
                mem_read  = !dma_we;
                mem_write = dma_we;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                dma_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    // A CPU preempt inside a burst leaves state and beat count untouched.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (dma_gnt) begin
                    beat_cnt_d = BEAT_ONE;
                    if (!dma_last && MAX_BURST != 1) begin
                        state_d = DMA_BURST;
                    end
                end
            end
            DMA_BURST: begin
                if (!dma_req) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (dma_gnt) begin
                    if (dma_last || beat_cnt_q == BEAT_LAST) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] dma_beats_q, dma_beats_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        dma_beats_d    = dma_beats_q;
        if (cpu_stall && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (dma_gnt && dma_beats_q != 16'hFFFF) begin
            dma_beats_d = dma_beats_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            dma_beats_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            dma_beats_q    <= dma_beats_d;
        end
    end

    assign stat_cpu_stall_cycles = stall_cycles_q;
    assign stat_dma_beats        = dma_beats_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a behavioural arbitration model.
module tb_dmem_arbiter;
    localparam int MB = 8;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we, dma_last;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0] stat_cpu_stall_cycles, stat_dma_beats;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(MB), .STARVE_LIMIT(SL)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_last  (dma_last),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rdata (dma_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARBITER_STATS_EN
        ,
        .stat_cpu_stall_cycles (stat_cpu_stall_cycles),
        .stat_dma_beats        (stat_dma_beats)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req   = 1'b0; dma_we = 1'b0; dma_last = 1'b0;
        dma_addr  = '0;   dma_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1234; cpu_wdata = 32'h5678;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h9ABC; dma_wdata = 32'hDEF0;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt got=%0h exp=0", cpu_gnt); else passed++;
        checks++; if (dma_gnt !== 1'b0) $display("FAIL rst_dma_gnt got=%0h exp=0", dma_gnt); else passed++;
        checks++; if (cpu_stall !== 1'b0) $display("FAIL rst_cpu_stall got=%0h exp=0", cpu_stall); else passed++;
        next_cycle();
        checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got=%0h exp=0", mem_write); else passed++;
        checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); else passed++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got=%0h exp=0", mem_wdata); else passed++;
        checks++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cpu_rdata got=%0h exp=0", cpu_rdata); else passed++;
        checks++; if (dma_rdata !== 32'h0) $display("FAIL rst_dma_rdata got=%0h exp=0", dma_rdata); else passed++;
`ifdef DMEM_ARBITER_STATS_EN
        checks++; if (stat_dma_beats !== 16'h0) $display("FAIL rst_stat_beats got=%0h exp=0", stat_dma_beats); else passed++;
`endif
    endtask

    task automatic test_both_req();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h11;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h22;
        #1;
        checks++; if (cpu_gnt !== 1'b1) $display("FAIL both_cpu_gnt got=%0h exp=1", cpu_gnt); else passed++;
        checks++; if (dma_gnt !== 1'b0) $display("FAIL both_dma_gnt got=%0h exp=0", dma_gnt); else passed++;
        checks++; if (mem_addr !== 32'h100) $display("FAIL both_mem_addr got=%0h exp=100", mem_addr); else passed++;
        checks++; if (mem_read !== 1'b1) $display("FAIL both_mem_read got=%0h exp=1", mem_read); else passed++;
        // CPU keeps issuing new accesses; DMA wait climbs 1..4 and then wins.
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            cpu_addr = 32'h100 + 32'(i * 4);
            #1;
            checks++; if (cpu_gnt !== 1'b1) $display("FAIL both_cpu_gnt_%0d got=%0h exp=1", i, cpu_gnt); else passed++;
        end
        next_cycle();
        #1;
        checks++; if (dma_gnt !== 1'b1) $display("FAIL dma_starve_gnt got=%0h exp=1", dma_gnt); else passed++;
        checks++; if (cpu_stall !== 1'b1) $display("FAIL dma_starve_stall got=%0h exp=1", cpu_stall); else passed++;
        checks++; if (mem_wdata !== 32'h22) $display("FAIL dma_starve_wdata got=%0h exp=22", mem_wdata); else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_burst3();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_last = (i == 3);
            dma_addr = 32'h40 + 32'(i * 4); dma_wdata = 32'(i * 32'h1111);
            #1;
            checks++; if (dma_gnt !== 1'b1) $display("FAIL b3_gnt_%0d got=%0h exp=1", i, dma_gnt); else passed++;
            checks++; if (mem_write !== 1'b1) $display("FAIL b3_write_%0d got=%0h exp=1", i, mem_write); else passed++;
            checks++; if (mem_addr !== 32'h40 + 32'(i * 4)) $display("FAIL b3_addr_%0d got=%0h exp=%0h", i, mem_addr, 32'h40 + 32'(i * 4)); else passed++;
            next_cycle();
        end
        cpu_req = 1'b1; cpu_addr = 32'h300; dma_last = 1'b0; dma_addr = 32'h50;
        #1;
        checks++; if (cpu_gnt !== 1'b1) $display("FAIL b3_idle_cpu_gnt got=%0h exp=1", cpu_gnt); else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_max_burst();
        apply_reset();
        for (int b = 1; b <= MB; b++) begin
            dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h1000 + 32'(b); mem_rdata = 32'(b);
            cpu_req = (b == 5); cpu_addr = 32'h30;
            #1;
            checks++; if (dma_gnt !== 1'b1) $display("FAIL mb_gnt_%0d got=%0h exp=1", b, dma_gnt); else passed++;
            checks++; if (dma_rdata !== 32'(b)) $display("FAIL mb_rdata_%0d got=%0h exp=%0h", b, dma_rdata, b); else passed++;
            if (b == 5) begin
                checks++; if (cpu_stall !== 1'b1) $display("FAIL mb_cpu_stall got=%0h exp=1", cpu_stall); else passed++;
            end
            next_cycle();
        end
        cpu_req = 1'b1; dma_addr = 32'h1009;
        #1;
        checks++; if (cpu_gnt !== 1'b1) $display("FAIL mb_release_cpu got=%0h exp=1", cpu_gnt); else passed++;
        checks++; if (dma_gnt !== 1'b0) $display("FAIL mb_release_dma got=%0h exp=0", dma_gnt); else passed++;
        next_cycle();
        cpu_req = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b1) $display("FAIL mb_beat9_gnt got=%0h exp=1", dma_gnt); else passed++;
        checks++; if (mem_addr !== 32'h1009) $display("FAIL mb_beat9_addr got=%0h exp=1009", mem_addr); else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starve();
        apply_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h2000; dma_wdata = 32'hA5A5;
        #1;
        checks++; if (dma_gnt !== 1'b1) $display("FAIL st_beat1 got=%0h exp=1", dma_gnt); else passed++;
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        for (int c = 1; c <= SL; c++) begin
            #1;
            checks++; if (cpu_stall !== 1'b1) $display("FAIL st_stall_%0d got=%0h exp=1", c, cpu_stall); else passed++;
            checks++; if (dma_gnt !== 1'b1) $display("FAIL st_dma_%0d got=%0h exp=1", c, dma_gnt); else passed++;
            next_cycle();
        end
        #1;
        checks++; if (cpu_gnt !== 1'b1) $display("FAIL st_preempt_cpu got=%0h exp=1", cpu_gnt); else passed++;
        checks++; if (dma_gnt !== 1'b0) $display("FAIL st_preempt_dma got=%0h exp=0", dma_gnt); else passed++;
        checks++; if (mem_addr !== 32'h80) $display("FAIL st_preempt_addr got=%0h exp=80", mem_addr); else passed++;
        next_cycle();
        // Five beats done; three remain before forced release.
        cpu_addr = 32'h84;
        for (int b = 6; b <= MB; b++) begin
            #1;
            checks++; if (dma_gnt !== 1'b1) $display("FAIL st_resume_%0d got=%0h exp=1", b, dma_gnt); else passed++;
            next_cycle();
        end
        #1;
        checks++; if (cpu_gnt !== 1'b1) $display("FAIL st_after_burst_cpu got=%0h exp=1", cpu_gnt); else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_load_data();
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL ld_cpu_rdata got=%0h exp=deadbeef", cpu_rdata); else passed++;
        checks++; if (dma_rdata !== 32'h0) $display("FAIL ld_dma_rdata got=%0h exp=0", dma_rdata); else passed++;
        checks++; if (mem_addr !== 32'h10) $display("FAIL ld_mem_addr got=%0h exp=10", mem_addr); else passed++;
        checks++; if (mem_write !== 1'b0) $display("FAIL ld_mem_write got=%0h exp=0", mem_write); else passed++;
        next_cycle();
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_last = 1'b1; dma_addr = 32'h14; mem_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (dma_rdata !== 32'hCAFEF00D) $display("FAIL ld_dma_read got=%0h exp=cafef00d", dma_rdata); else passed++;
        checks++; if (cpu_rdata !== 32'h0) $display("FAIL ld_cpu_zero got=%0h exp=0", cpu_rdata); else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h3000; dma_wdata = 32'h77;
        next_cycle();
        #1;
        checks++; if (dma_gnt !== 1'b1) $display("FAIL rmb_beat2 got=%0h exp=1", dma_gnt); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b0) $display("FAIL rmb_gnt got=%0h exp=0", dma_gnt); else passed++;
        checks++; if (mem_write !== 1'b0) $display("FAIL rmb_write got=%0h exp=0", mem_write); else passed++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL rmb_wdata got=%0h exp=0", mem_wdata); else passed++;
`ifdef DMEM_ARBITER_STATS_EN
        checks++; if (stat_dma_beats !== 16'h0) $display("FAIL rmb_stat_beats got=%0h exp=0", stat_dma_beats); else passed++;
        checks++; if (stat_cpu_stall_cycles !== 16'h0) $display("FAIL rmb_stat_stall got=%0h exp=0", stat_cpu_stall_cycles); else passed++;
`endif
        next_cycle();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'h40;
        #1;
        checks++; if (cpu_gnt !== 1'b1) $display("FAIL rmb_rearb_cpu got=%0h exp=1", cpu_gnt); else passed++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        bit          m_burst, cpu_pend, dma_pend;
        int          m_beat, m_cw, m_dw;
        logic        e_cpu, e_dma, e_read, e_write;
        logic [31:0] e_addr, e_wdata, e_crd, e_drd;
        apply_reset();
        m_burst = 0; m_beat = 0; m_cw = 0; m_dw = 0; cpu_pend = 0; dma_pend = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!cpu_pend) begin
                cpu_pend  = ($urandom_range(0, 2) == 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            if (!dma_pend) begin
                dma_pend  = ($urandom_range(0, 4) != 0);
                dma_we    = 1'($urandom_range(0, 1));
                dma_last  = ($urandom_range(0, 5) == 0);
                dma_addr  = $urandom;
                dma_wdata = $urandom;
            end
            cpu_req   = cpu_pend;
            dma_req   = dma_pend;
            mem_rdata = $urandom;
            #1;
            e_cpu = 1'b0; e_dma = 1'b0;
            if (cpu_req && m_cw >= SL)                 e_cpu = 1'b1;
            else if (m_burst && dma_req)               e_dma = 1'b1;
            else if (!m_burst && dma_req && m_dw >= SL) e_dma = 1'b1;
            else if (cpu_req)                          e_cpu = 1'b1;
            else if (dma_req)                          e_dma = 1'b1;
            e_read  = (e_cpu && !cpu_we) || (e_dma && !dma_we);
            e_write = (e_cpu && cpu_we) || (e_dma && dma_we);
            e_addr  = e_cpu ? cpu_addr  : (e_dma ? dma_addr  : 32'h0);
            e_wdata = e_cpu ? cpu_wdata : (e_dma ? dma_wdata : 32'h0);
            e_crd   = e_cpu ? mem_rdata : 32'h0;
            e_drd   = e_dma ? mem_rdata : 32'h0;
            checks++; if (cpu_gnt !== e_cpu) $display("FAIL rnd_cpu_gnt cyc=%0d got=%0h exp=%0h", cyc, cpu_gnt, e_cpu); else passed++;
            checks++; if (dma_gnt !== e_dma) $display("FAIL rnd_dma_gnt cyc=%0d got=%0h exp=%0h", cyc, dma_gnt, e_dma); else passed++;
            checks++; if (cpu_stall !== (cpu_req && !e_cpu)) $display("FAIL rnd_stall cyc=%0d got=%0h exp=%0h", cyc, cpu_stall, cpu_req && !e_cpu); else passed++;
            checks++; if (mem_read !== e_read) $display("FAIL rnd_read cyc=%0d got=%0h exp=%0h", cyc, mem_read, e_read); else passed++;
            checks++; if (mem_write !== e_write) $display("FAIL rnd_write cyc=%0d got=%0h exp=%0h", cyc, mem_write, e_write); else passed++;
            checks++; if (mem_addr !== e_addr) $display("FAIL rnd_addr cyc=%0d got=%0h exp=%0h", cyc, mem_addr, e_addr); else passed++;
            checks++; if (mem_wdata !== e_wdata) $display("FAIL rnd_wdata cyc=%0d got=%0h exp=%0h", cyc, mem_wdata, e_wdata); else passed++;
            checks++; if (cpu_rdata !== e_crd) $display("FAIL rnd_cpu_rdata cyc=%0d got=%0h exp=%0h", cyc, cpu_rdata, e_crd); else passed++;
            checks++; if (dma_rdata !== e_drd) $display("FAIL rnd_dma_rdata cyc=%0d got=%0h exp=%0h", cyc, dma_rdata, e_drd); else passed++;
            m_cw = (cpu_req && !e_cpu) ? ((m_cw + 1 > SL) ? SL : m_cw + 1) : 0;
            m_dw = (dma_req && !e_dma) ? ((m_dw + 1 > SL) ? SL : m_dw + 1) : 0;
            if (!m_burst) begin
                if (e_dma) begin
                    m_beat  = 1;
                    m_burst = !(dma_last || MB == 1);
                end
            end else if (!dma_req) begin
                m_burst = 0;
            end else if (e_dma) begin
                m_beat++;
                if (dma_last || m_beat >= MB) m_burst = 0;
            end
            if (e_cpu) cpu_pend = 0;
            if (e_dma) dma_pend = 0;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_both_req();
        test_burst3();
        test_max_burst();
        test_starve();
        test_load_data();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum DMA beats per burst before forced release.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles before the waiting requester is force-granted.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cpu_req/cpu_we  in  1 each  CPU MEM-stage access request, 1=store.
REQ-006 SHALL have ports cpu_addr/cpu_wdata  in  32 each  CPU address, store data.
REQ-007 SHALL have ports cpu_gnt/cpu_stall  out  1 each  CPU access performed this cycle, CPU must hold pipeline.
REQ-008 SHALL have port cpu_rdata  out  32  load data, valid when cpu_gnt.
REQ-009 SHALL have ports dma_req/dma_we/dma_last  in  1 each  loader/debug request, 1=write, final beat of burst.
REQ-010 SHALL have ports dma_addr/dma_wdata  in  32 each; dma_gnt  out  1; dma_rdata  out  32.
REQ-011 SHALL have ports mem_read/mem_write  out  1 each; mem_addr/mem_wdata  out  32 each; mem_rdata  in  32 (single-port data memory, combinational read).

Function
REQ-012 SHALL implement FSM states IDLE and DMA_BURST; at most one grant per cycle.
REQ-013 SHALL compute grants combinationally from registered state/counters and current requests (zero-cycle grant latency); requester holds req/addr/data until granted.
REQ-014 Priority, first match: (a) cpu_req && cpu_wait>=STARVE_LIMIT -> CPU; (b) DMA_BURST && dma_req -> DMA; (c) IDLE && dma_req && dma_wait>=STARVE_LIMIT -> DMA; (d) cpu_req -> CPU; (e) dma_req -> DMA.
REQ-015 IDLE -> DMA_BURST on dma_gnt unless dma_last or MAX_BURST==1; beat_cnt loads 1.
REQ-016 DMA_BURST: each dma_gnt increments beat_cnt; -> IDLE on dma_gnt with dma_last or beat_cnt==MAX_BURST-1, or on any cycle with dma_req low (burst abandoned).
REQ-017 CPU starvation preempt (14a) mid-burst SHALL NOT change state or beat_cnt; DMA resumes next cycle.
REQ-018 cpu_wait/dma_wait SHALL count consecutive cycles req && !gnt, saturate at STARVE_LIMIT, clear on own grant or req low.
REQ-019 cpu_stall SHALL equal cpu_req && !cpu_gnt.
REQ-020 mem_read = grant && !we; mem_write = grant && we; mem_addr/mem_wdata muxed from granted port, all zero when no grant.
REQ-021 cpu_rdata/dma_rdata SHALL equal mem_rdata when that port is granted, else 0.

Reset
REQ-022 reset low SHALL immediately force state IDLE, beat_cnt/cpu_wait/dma_wait 0, cpu_gnt/dma_gnt/mem_read/mem_write 0, all data outputs 0, cpu_stall 0, regardless of inputs.
REQ-023 Reset mid-burst SHALL discard the burst; after release the first DMA beat re-arbitrates from IDLE.

Configuration
REQ-024 With DMEM_ARBITER_STATS_EN defined, SHALL add outputs stat_cpu_stall_cycles (16) and stat_dma_beats (16): saturating counters of cpu_stall cycles and dma_gnt beats, cleared by reset.
REQ-025 Without DMEM_ARBITER_STATS_EN, those ports and counters SHALL be absent; arbitration unchanged.

Structure
REQ-026 SHALL place state enum (IDLE, DMA_BURST), default MAX_BURST/STARVE_LIMIT and port-id constants in shared package dmem_arb_pkg.
REQ-027 SHALL instantiate sub-module arb_wait_counter (saturating consecutive-wait counter) once per requester.

Verification
REQ-028 cpu_req and dma_req both high from IDLE, waits 0 -> cpu_gnt=1, dma_gnt=0, mem_addr=cpu_addr, dma_wait=1.
REQ-029 DMA burst of 3 beats (dma_last on 3rd), no CPU -> dma_gnt 3 consecutive cycles, mem_write each beat, IDLE after 3rd.
REQ-030 DMA 20-beat request, no dma_last, MAX_BURST=8 -> IDLE after beat 8; beat 9 re-granted from IDLE (CPU idle).
REQ-031 Mid-burst cpu_req held, STARVE_LIMIT=4 -> cpu_stall 4 cycles, cpu_gnt on 5th, DMA resumes next cycle with beat_cnt unchanged.
REQ-032 CPU load addr 0x10, mem_rdata=0xDEADBEEF -> cpu_rdata=0xDEADBEEF same cycle, dma_rdata=0.
REQ-033 reset driven low at beat 2 of burst -> gnts and mem_write drop without clock edge; stats (if enabled) read 0.
